// File: rtl/serial_alu_seq_if.sv
// Word-level request/result bundle for serial_alu_seq.
// The ovf signal exists only when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  // Handshake: a request is taken on a rising edge where ready=1 and start=1;
  // a/b/op are sampled on that edge only. done pulses for one cycle when y,
  // cout, zero (and ovf) have been refreshed; they then hold until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zero;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf;
`endif
  logic [1:0]       fsm_state;

`ifdef SERIAL_ALU_OVF_EN
  modport master (
    output start, a, b, op,
    input  ready, busy, done, y, cout, zero, ovf, fsm_state
  );
  modport slave (
    input  start, a, b, op,
    output ready, busy, done, y, cout, zero, ovf, fsm_state
  );
`else
  modport master (
    output start, a, b, op,
    input  ready, busy, done, y, cout, zero, fsm_state
  );
  modport slave (
    input  start, a, b, op,
    output ready, busy, done, y, cout, zero, fsm_state
  );
`endif
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial WIDTH-bit ALU (AND/OR/XOR/ADD), LSB first, one bit per clock.
// Optional signed-overflow flag is compiled in with SERIAL_ALU_OVF_EN.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] y_sh;
  logic [1:0]       op_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             ready_w;
  logic             accept;
  logic             last_bit;
  logic             bit_r;
  logic             carry_nxt;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] y_r;
  logic             cout_r;
  logic             zero_r;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = last_bit ? DONE : RUN;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready_w  = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      IDLE:    ready_w  = 1'b1;
      RUN:     bus.busy = 1'b1;
      DONE: begin
        ready_w  = 1'b1;
        bus.done = 1'b1;
      end
      default: ready_w  = 1'b0;
    endcase
  end

  assign bus.ready     = ready_w;
  assign bus.fsm_state = state;
  assign accept        = ready_w & bus.start;
  assign last_bit      = (cnt == CW'(WIDTH - 1));

  // ---------------- single-bit ALU ----------------
  always_comb begin
    bit_r     = 1'b0;
    carry_nxt = carry;
    unique case (op_r)
      OP_AND: bit_r = a_sh[0] & b_sh[0];
      OP_OR:  bit_r = a_sh[0] | b_sh[0];
      OP_XOR: bit_r = a_sh[0] ^ b_sh[0];
      OP_ADD: begin
        bit_r     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      end
      default: bit_r = 1'b0;
    endcase
  end

  // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign word = {bit_r, y_sh};

  // ---------------- operand / accumulator shifters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      y_sh  <= '0;
      op_r  <= OP_AND;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      y_sh  <= '0;
      op_r  <= bus.op;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      y_sh  <= word[WIDTH-1:1];
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

  // ---------------- registered results ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r    <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (state == RUN && last_bit) begin
      y_r    <= word;
      cout_r <= (op_r == OP_ADD) ? carry_nxt : 1'b0;
      zero_r <= (word == '0);
    end
  end

  assign bus.y    = y_r;
  assign bus.cout = cout_r;
  assign bus.zero = zero_r;

`ifdef SERIAL_ALU_OVF_EN
  logic ovf_r;

  // On the last bit, carry holds the carry into the MSB and carry_nxt the carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf_r <= (op_r == OP_ADD) ? (carry ^ carry_nxt) : 1'b0;
    end
  end

  assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomised plus directed bench for serial_alu_seq with an arithmetic reference
// model and a queue-based scoreboard; ovf is checked when SERIAL_ALU_OVF_EN is set.
module tb_serial_alu_seq;

  localparam int W = 8;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         zero;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t exp_q[$];

  serial_alu_seq_if #(.WIDTH(W)) intf ();

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    exp_t       e;
    logic [W:0] sum;
    sum    = {1'b0, x} + {1'b0, z};
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (o)
      OP_AND:  e.y = x & z;
      OP_OR:   e.y = x | z;
      OP_XOR:  e.y = x ^ z;
      default: begin
        e.y    = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (x[W-1] == z[W-1]) && (sum[W-1] != x[W-1]);
      end
    endcase
    e.zero = (e.y == '0);
    e.acc  = 0;
    return e;
  endfunction

  // ---------------- scoreboard: push on every accepting edge ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst && intf.ready && intf.start) begin
      e     = model(intf.op, intf.a, intf.b);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor: pop and compare on every done ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else if (intf.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_y", 32'(intf.y), 32'(e.y));
        check("sb_cout", 32'(intf.cout), 32'(e.cout));
        check("sb_zero", 32'(intf.zero), 32'(e.zero));
`ifdef SERIAL_ALU_OVF_EN
        check("sb_ovf", 32'(intf.ovf), 32'(e.ovf));
`endif
        check("sb_latency", 32'(cyc - e.acc), 32'(W));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    int k = 0;
    @(posedge clk); #1;
    while (!intf.ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!intf.ready) check("ready_timeout", 32'd0, 32'd1);
    intf.start = 1'b1;
    intf.op    = o;
    intf.a     = x;
    intf.b     = z;
    @(posedge clk); #1;
    intf.start = 1'b0;
    intf.a     = W'($urandom);
    intf.b     = W'($urandom);
    intf.op    = 2'($urandom);
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] ey,
                               input logic ec, input logic ez);
    int k = 0;
    @(negedge clk);
    while (!intf.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!intf.done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_y"}, 32'(intf.y), 32'(ey));
      check({name, "_cout"}, 32'(intf.cout), 32'(ec));
      check({name, "_zero"}, 32'(intf.zero), 32'(ez));
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || intf.busy) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (intf.done) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nd;
    int bad;
    int gap;

    rst        = 1'b1;
    intf.start = 1'b0;
    intf.a     = '0;
    intf.b     = '0;
    intf.op    = OP_AND;
    #1;
    check("rst_ready", 32'(intf.ready), 32'd1);
    check("rst_busy", 32'(intf.busy), 32'd0);
    check("rst_done", 32'(intf.done), 32'd0);
    check("rst_y", 32'(intf.y), 32'd0);
    check("rst_zero", 32'(intf.zero), 32'd0);
    check("rst_cout", 32'(intf.cout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors.
    do_op(OP_ADD, 8'hFF, 8'h01);
    expect_result("add_ff_01", 8'h00, 1'b1, 1'b1);
    do_op(OP_AND, 8'hF0, 8'h3C);
    expect_result("and_f0_3c", 8'h30, 1'b0, 1'b0);
    do_op(OP_OR, 8'hA0, 8'h05);
    expect_result("or_a0_05", 8'hA5, 1'b0, 1'b0);
    do_op(OP_XOR, 8'hAA, 8'hAA);
    expect_result("xor_aa_aa", 8'h00, 1'b0, 1'b1);

    // A start pulse during RUN with new operands must be ignored.
    do_op(OP_ADD, 8'h12, 8'h34);
    repeat (2) begin @(posedge clk); #1; end
    intf.start = 1'b1;
    intf.op    = OP_ADD;
    intf.a     = 8'hFF;
    intf.b     = 8'hFF;
    @(posedge clk); #1;
    intf.start = 1'b0;
    intf.a     = 8'h77;
    expect_result("add_12_34", 8'h46, 1'b0, 1'b0);
    count_dones(12, nd);
    check("ignored_start_dones", 32'(nd), 32'd0);
    wait_idle();

    // Start held high: one result every W+1 cycles, ready only in DONE.
    @(posedge clk); #1;
    intf.start = 1'b1;
    intf.op    = OP_ADD;
    intf.a     = 8'h01;
    intf.b     = 8'h01;
    @(posedge clk);
    nd  = 0;
    bad = 0;
    for (int i = 0; i < 3 * (W + 1); i++) begin
      @(negedge clk);
      if (intf.done) nd++;
      if (intf.ready != intf.done) bad++;
    end
    @(posedge clk); #1;
    intf.start = 1'b0;
    check("held_start_dones", 32'(nd), 32'd3);
    check("held_start_ready_outside_done", 32'(bad), 32'd0);
    check("held_start_y", 32'(intf.y), 32'h02);
    wait_idle();

    // Reset in the middle of RUN aborts without a done.
    do_op(OP_ADD, 8'h0F, 8'h01);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_y", 32'(intf.y), 32'd0);
    check("abort_ready", 32'(intf.ready), 32'd1);
    check("abort_busy", 32'(intf.busy), 32'd0);
    check("abort_done", 32'(intf.done), 32'd0);
    check("abort_cout", 32'(intf.cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_dones(12, nd);
    check("abort_no_done", 32'(nd), 32'd0);
    do_op(OP_XOR, 8'h5A, 8'hFF);
    expect_result("xor_5a_ff", 8'hA5, 1'b0, 1'b0);

`ifdef SERIAL_ALU_OVF_EN
    do_op(OP_ADD, 8'h7F, 8'h01);
    expect_result("ovf_add_7f_01", 8'h80, 1'b0, 1'b0);
    check("ovf_add_7f_01_ovf", 32'(intf.ovf), 32'd1);
    do_op(OP_ADD, 8'hFF, 8'h01);
    expect_result("ovf_add_ff_01", 8'h00, 1'b1, 1'b1);
    check("ovf_add_ff_01_ovf", 32'(intf.ovf), 32'd0);
    do_op(OP_AND, 8'hFF, 8'hFF);
    expect_result("ovf_and_ff_ff", 8'hFF, 1'b0, 1'b0);
    check("ovf_and_ff_ff_ovf", 32'(intf.ovf), 32'd0);
`endif

    // Randomised operations with ignored mid-RUN start pulses and varied gaps.
    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 9) < 3) begin
        gap = $urandom_range(0, W - 3);
        repeat (gap) begin @(posedge clk); #1; end
        intf.start = 1'b1;
        @(posedge clk); #1;
        intf.start = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
    end
    wait_idle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_seen", 32'(n_done > 60), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial multi-bit ALU sequencer. It accepts a WIDTH-bit operation (AND, OR, XOR, ADD) through a start/ready/done handshake and evaluates it LSB-first, one bit per clock, with a 1-bit datapath and a carry flop. It initiates and drives single-bit ALU evaluation on behalf of word-level logic, and returns the assembled word, carry-out and flags. It is intended for area-constrained paths where one result every WIDTH+1 cycles is sufficient.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only on edges where ready=1.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD; captured on the accepting edge.
- ready  output  1  block can accept start this cycle.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; y/cout/zero are valid and newly updated.
- y  output  WIDTH  result; registered, holds until the next completion.
- cout  output  1  carry out of the MSB for ADD; 0 for logic ops.
- zero  output  1  1 when y==0; registered with y.
- ovf  output  1  signed overflow for ADD; present only with SERIAL_ALU_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - ready = (IDLE or DONE).
  - busy = RUN.
  - done = DONE.
- Accepting edge (ready & start):
  - Load a_sh<=a, b_sh<=b, op_r<=op.
  - Clear carry and bit counter cnt.
  - Go to RUN.
- RUN, each edge:
  - Compute bit r from a_sh[0], b_sh[0], op_r: AND, OR, XOR, or ADD sum = a^b^carry.
  - carry <= majority(a,b,carry), updated for ADD only.
  - Shift r into the MSB of y_sh; shift a_sh and b_sh right by one.
  - cnt++.
  - On the edge where cnt==WIDTH-1:
    - Load y<=assembled word, cout<=final carry (0 for logic ops), zero<=(word==0).
    - Go to DONE.
- DONE: lasts one cycle. Goes to RUN if start=1 (new operands captured), else to IDLE.
- Arithmetic: ADD result is (a+b) mod 2^WIDTH; the carry is the true (WIDTH+1)th bit. Operands are unsigned except for ovf.
- start while busy is ignored; it is neither queued nor errored.
- Changes on a/b/op after the accepting edge have no effect on the running operation.
- Reset, at any time including mid-RUN:
  - State goes to IDLE and the shifters, counter and carry clear.
  - y=0, cout=0, zero=0, ovf=0, done=0, busy=0, ready=1.
  - An aborted operation never produces done.

## Timing
- Accepting edge is E0. Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- Outputs update at EWIDTH, so done is high between EWIDTH and EWIDTH+1.
- Latency: WIDTH cycles from the accepting edge to done.
- Throughput: back-to-back start held high gives one result per WIDTH+1 cycles, because DONE accepts the next start.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - Adds the ovf port.
  - For ADD, ovf = carry into MSB XOR carry out of MSB, latched with y. ovf=0 for logic ops.
- SERIAL_ALU_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01 -> done exactly 8 cycles after the accepting edge; y=0x00, cout=1, zero=1.
- AND 0xF0,0x3C -> y=0x30, cout=0, zero=0. OR 0xA0,0x05 -> y=0xA5. XOR 0xAA,0xAA -> y=0x00, zero=1.
- Start ADD 0x12+0x34; pulse start with a=0xFF b=0xFF during RUN and change a/b -> single done, y=0x46, cout=0.
- Start held high continuously with ADD 0x01+0x01 -> done pulses every 9 cycles, y=0x02 each time, ready=1 only in DONE.
- Assert rst at the 4th RUN cycle of ADD 0x0F+0x01 -> immediately y=0, ready=1, busy=0, no done. Then XOR 0x5A,0xFF -> y=0xA5.
- With SERIAL_ALU_OVF_EN: ADD 0x7F+0x01 -> y=0x80, ovf=1, cout=0. ADD 0xFF+0x01 -> ovf=0, cout=1. AND 0xFF,0xFF -> ovf=0.
